// File: rtl/prog_loader.sv
// Program-memory loader: debounced keys assemble 16-bit words from switch bytes and write them to program RAM.
// Optional running checksum of written words is built only when PROG_LOADER_CHECKSUM_EN is defined.

module prog_loader_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;

  assign w_diff  = r_sync2 ^ r_stable;
  assign o_press = r_press;

  // Accept a new level only after it has differed from the stable level for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_press  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

module prog_loader #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DEBOUNCE_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        sw,
  input  logic              key_byte_n,
  input  logic              key_done_n,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   word_count,
  output logic [2:0]        state_led,
  output logic [15:0]       checksum
);

  typedef enum logic [1:0] {
    S_LOAD_HI = 2'd0,
    S_LOAD_LO = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W:0]   WC_FULL   = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_byte_p;
  logic              w_done_p;
  logic              w_lat_hi;
  logic              w_lat_lo;
  logic              w_commit;
  logic [2:0]        w_led_nxt;
  logic [15:0]       w_word;

  logic [7:0]        r_hi;
  logic [7:0]        r_lo;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic              r_cpu_rst;
  logic [ADDR_W:0]   r_wc;
  logic [2:0]        r_led;

  prog_loader_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_byte (
    .clk     (clk),
    .rst     (rst),
    .i_key_n (key_byte_n),
    .o_press (w_byte_p)
  );

  prog_loader_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_done (
    .clk     (clk),
    .rst     (rst),
    .i_key_n (key_done_n),
    .o_press (w_done_p)
  );

  assign w_word = {r_hi, r_lo};

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_LOAD_HI;
    else      r_state <= w_state_nxt;
  end

  // Done beats a simultaneous byte; WRITE always completes before DONE can be entered.
  always_comb begin
    w_state_nxt = r_state;
    w_lat_hi    = 1'b0;
    w_lat_lo    = 1'b0;
    w_commit    = 1'b0;
    w_led_nxt   = 3'b001;
    case (r_state)
      S_LOAD_HI: begin
        if (w_done_p) begin
          w_state_nxt = S_DONE;
        end else if (w_byte_p) begin
          w_lat_hi    = 1'b1;
          w_state_nxt = S_LOAD_LO;
        end
      end
      S_LOAD_LO: begin
        if (w_done_p) begin
          w_state_nxt = S_DONE;
        end else if (w_byte_p) begin
          w_lat_lo    = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        w_commit    = 1'b1;
        w_state_nxt = (r_addr == ADDR_LAST) ? S_DONE : S_LOAD_HI;
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_LOAD_HI;
      end
    endcase
    case (w_state_nxt)
      S_LOAD_LO: w_led_nxt = 3'b010;
      S_DONE:    w_led_nxt = 3'b100;
      default:   w_led_nxt = 3'b001;
    endcase
  end

  // Registered outputs and datapath; address/count advance on the edge that ends WRITE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_cpu_rst <= 1'b1;
      r_wc      <= '0;
      r_led     <= 3'b001;
    end else begin
      r_we      <= (w_state_nxt == S_WRITE);
      r_cpu_rst <= (w_state_nxt != S_DONE);
      r_led     <= w_led_nxt;
      if (w_lat_hi) r_hi <= sw;
      if (w_lat_lo) r_lo <= sw;
      if (w_commit) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (r_wc != WC_FULL) r_wc <= r_wc + (ADDR_W+1)'(1);
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [15:0] r_sum;

  // Sum lands together with the word_count update, so it is final for that word.
  always_ff @(posedge clk) begin
    if (!rst)          r_sum <= '0;
    else if (w_commit) r_sum <= r_sum + w_word;
  end

  assign checksum = r_sum;
`else
  assign checksum = 16'h0000;
`endif

  assign prog_we    = r_we;
  assign prog_addr  = r_addr;
  assign prog_data  = w_word;
  assign cpu_rst    = r_cpu_rst;
  assign word_count = r_wc;
  assign state_led  = r_led;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (ADDR_W=2, DEBOUNCE_CYC=4); expected RAM writes are queued and checked by a write monitor.

module tb_prog_loader;

  localparam int DEB = 4;
  localparam int AW  = 2;
  localparam int HOLD = DEB + 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    sw;
  logic          key_byte_n;
  logic          key_done_n;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          cpu_rst;
  logic [AW:0]   word_count;
  logic [2:0]    state_led;
  logic [15:0]   checksum;

  int total = 0;
  int bad   = 0;
  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] w_exp;

  prog_loader #(.ADDR_W(AW), .DEBOUNCE_CYC(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .key_byte_n (key_byte_n),
    .key_done_n (key_done_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .cpu_rst    (cpu_rst),
    .word_count (word_count),
    .state_led  (state_led),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cs_exp(input logic [15:0] v);
`ifdef PROG_LOADER_CHECKSUM_EN
    return v;
`else
    return 16'h0000 & v;
`endif
  endfunction

  // Every prog_we pulse must match the oldest queued {addr, data}.
  always @(negedge clk) begin
    if (prog_we === 1'b1) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_write observed=%0h expected=none", {prog_addr, prog_data});
      end
      if (exp_q.size() > 0) begin
        w_exp = exp_q.pop_front();
        chk("write_addr_data", 32'({prog_addr, prog_data}), 32'(w_exp));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_byte(input logic [7:0] v);
    sw = v;
    key_byte_n = 1'b0;
    wait_cyc(HOLD);
    key_byte_n = 1'b1;
    wait_cyc(HOLD);
  endtask

  task automatic press_done();
    key_done_n = 1'b0;
    wait_cyc(HOLD);
    key_done_n = 1'b1;
    wait_cyc(HOLD);
  endtask

  task automatic enter_word(input logic [15:0] w, input logic [AW-1:0] a);
    exp_q.push_back({a, w});
    press_byte(w[15:8]);
    press_byte(w[7:0]);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},    32'(prog_we),    32'(0));
    chk({tag, "_addr"},  32'(prog_addr),  32'(0));
    chk({tag, "_data"},  32'(prog_data),  32'(0));
    chk({tag, "_cpurst"}, 32'(cpu_rst),   32'(1));
    chk({tag, "_wc"},    32'(word_count), 32'(0));
    chk({tag, "_led"},   32'(state_led),  32'(3'b001));
    chk({tag, "_cs"},    32'(checksum),   32'(0));
  endtask

  task automatic do_reset();
    key_byte_n = 1'b1;
    key_done_n = 1'b1;
    rst = 1'b0;
    wait_cyc(3);
    chk_reset_vals("reset");
    rst = 1'b1;
    wait_cyc(2);
  endtask

  initial begin
    rst = 1'b0;
    sw = 8'h00;
    key_byte_n = 1'b1;
    key_done_n = 1'b1;
    wait_cyc(1);
    do_reset();

    // Single word, then two more and done
    enter_word(16'h8105, 2'd0);
    chk("single_wc", 32'(word_count), 32'(1));
    chk("single_led", 32'(state_led), 32'(3'b001));
    chk("single_cpurst", 32'(cpu_rst), 32'(1));
    chk("single_addr", 32'(prog_addr), 32'(1));
    enter_word(16'h1100, 2'd1);
    enter_word(16'hD000, 2'd2);
    chk("three_wc", 32'(word_count), 32'(3));
    chk("three_cs", 32'(checksum), 32'(cs_exp(16'h6205)));
    press_done();
    chk("done_cpurst", 32'(cpu_rst), 32'(0));
    chk("done_led", 32'(state_led), 32'(3'b100));
    press_byte(8'h55);
    press_byte(8'h66);
    chk("done_ignore_wc", 32'(word_count), 32'(3));
    chk("done_ignore_led", 32'(state_led), 32'(3'b100));

    // Bounce then long hold: exactly one byte accepted
    do_reset();
    sw = 8'h3C;
    key_byte_n = 1'b0; wait_cyc(1);
    key_byte_n = 1'b1; wait_cyc(1);
    key_byte_n = 1'b0; wait_cyc(1);
    key_byte_n = 1'b1; wait_cyc(1);
    key_byte_n = 1'b0; wait_cyc(100);
    key_byte_n = 1'b1; wait_cyc(HOLD);
    chk("bounce_led", 32'(state_led), 32'(3'b010));
    chk("bounce_wc", 32'(word_count), 32'(0));
    exp_q.push_back({2'd0, 16'h3C5A});
    press_byte(8'h5A);
    chk("bounce_word_wc", 32'(word_count), 32'(1));

    // Partial word discarded on done
    do_reset();
    press_byte(8'hAA);
    chk("partial_led_lo", 32'(state_led), 32'(3'b010));
    press_done();
    chk("partial_led", 32'(state_led), 32'(3'b100));
    chk("partial_wc", 32'(word_count), 32'(0));
    chk("partial_cpurst", 32'(cpu_rst), 32'(0));

    // Simultaneous byte and done: done wins
    do_reset();
    sw = 8'h77;
    key_byte_n = 1'b0;
    key_done_n = 1'b0;
    wait_cyc(HOLD);
    key_byte_n = 1'b1;
    key_done_n = 1'b1;
    wait_cyc(HOLD);
    chk("simul_led", 32'(state_led), 32'(3'b100));
    chk("simul_wc", 32'(word_count), 32'(0));
    chk("simul_data", 32'(prog_data), 32'(0));

    // Checksum wrap, then reset while in LOAD_LO
    do_reset();
    enter_word(16'hFFFF, 2'd0);
    enter_word(16'h0002, 2'd1);
    chk("cs_wrap", 32'(checksum), 32'(cs_exp(16'h0001)));
    press_byte(8'h12);
    chk("midrst_led_lo", 32'(state_led), 32'(3'b010));
    rst = 1'b0;
    wait_cyc(1);
    chk_reset_vals("midrst");
    rst = 1'b1;
    wait_cyc(2);

    // Full memory: four words then automatic DONE
    enter_word(16'h0102, 2'd0);
    enter_word(16'h0304, 2'd1);
    enter_word(16'h0506, 2'd2);
    enter_word(16'h0708, 2'd3);
    chk("full_led", 32'(state_led), 32'(3'b100));
    chk("full_wc", 32'(word_count), 32'(4));
    chk("full_addr", 32'(prog_addr), 32'(0));
    chk("full_cpurst", 32'(cpu_rst), 32'(0));
    chk("full_cs", 32'(checksum), 32'(cs_exp(16'h1014)));
    press_byte(8'h99);
    press_byte(8'h88);
    chk("full_hold_wc", 32'(word_count), 32'(4));

    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Front-end writer for the processor's instruction memory. It assembles 16-bit instruction words from two byte entries on the board switches, confirmed by key presses, and writes them sequentially into a dual-port program RAM. The processor fetches from the other port of that RAM. The block holds the processor in reset while loading and releases it once loading finishes.

## Interface

- `ADDR_W`, default 8: program memory address width; matches the processor's 8-bit PC.
- `DEBOUNCE_CYC`, default 50000: number of cycles a key must be stable before a press is accepted.
- `clk`, input, 1: system clock.
- `rst`, input, 1: synchronous, active-low reset. One clock domain; the polarity and synchronicity are fixed.
- `sw`, input, 8: byte value from the switches.
- `key_byte_n`, input, 1: active-low push button that enters the current `sw` byte.
- `key_done_n`, input, 1: active-low push button that ends loading.
- `prog_we`, output, 1: program RAM write enable (one-cycle pulse).
- `prog_addr`, output, ADDR_W: program RAM write address.
- `prog_data`, output, 16: program RAM write data, `{hi_byte, lo_byte}`.
- `cpu_rst`, output, 1: active-high reset to the processor.
- `word_count`, output, ADDR_W+1: number of words written so far.
- `state_led`, output, 3: one-hot state indicator: bit0 = LOAD_HI, bit1 = LOAD_LO, bit2 = DONE.
- `checksum`, output, 16: running sum of written words. See Configuration.

## Operation

- **Key conditioning:** each key passes through a 2-flop synchronizer, then a stability counter. A press is a stable 1→0 transition and produces a single-cycle internal pulse. Holding a key produces only one pulse.
- **State machine:** states are LOAD_HI, LOAD_LO, WRITE and DONE.
  - In LOAD_HI, a byte pulse latches `sw` as `hi_byte` and moves to LOAD_LO.
  - In LOAD_LO, a byte pulse latches `sw` as `lo_byte` and moves to WRITE.
  - WRITE lasts one cycle: `prog_we` = 1, `prog_data` = `{hi_byte, lo_byte}`, `prog_addr` = current address. The next cycle increments `prog_addr` and `word_count`, and the state returns to LOAD_HI.
  - In LOAD_HI or LOAD_LO, a done pulse moves to DONE. A pending `hi_byte` in LOAD_LO is discarded, with no write.
  - DONE is terminal until reset. It drives `cpu_rst` = 0 and ignores all key pulses.
- **Simultaneous presses:** if byte and done pulses occur in the same cycle, done wins and the byte is ignored.
- **Full memory:** after the write to address 2^ADDR_W−1, the state goes to DONE automatically. `prog_addr` wraps to 0, `word_count` = 2^ADDR_W, and no further writes occur.
- **State LEDs:** `state_led` shows LOAD_HI during WRITE.
- **Arithmetic:** `word_count` saturates at 2^ADDR_W. `checksum` is a modulo-2^16 sum.

## Timing

- **Reset values:** `prog_we` = 0, `prog_addr` = 0, `prog_data` = 0, `cpu_rst` = 1, `word_count` = 0, `state_led` = 3'b001, `checksum` = 0. Internal bytes = 0 and debounce counters = 0.
- **Key latency:** from the raw key falling edge to the internal pulse is 2 synchronizer cycles plus DEBOUNCE_CYC stable cycles. A bounce restarts the count.
- **Write latency:** `prog_we` asserts exactly 1 cycle after the low-byte pulse and lasts exactly 1 cycle. Address and data are valid in that same cycle. The RAM samples them on the next rising edge.
- **Release:** `cpu_rst` deasserts on the cycle DONE is entered and is registered (glitch-free). Any in-flight write completes before DONE is entered, because WRITE cannot be interrupted.
- **Reset mid-operation:** reset takes effect on the next edge from any state. It aborts a partial word, sets `prog_we` = 0 and reasserts `cpu_rst`. RAM contents are not cleared.

## Configuration

- `PROG_LOADER_CHECKSUM_EN` defined:
  - `checksum` accumulates `prog_data` on each WRITE cycle, updating the cycle after `prog_we`.
  - When `word_count` changes, `checksum` is already final for that word.
- `PROG_LOADER_CHECKSUM_EN` undefined:
  - The accumulator is not built.
  - `checksum` is tied to 16'h0000.

## Test plan

- **Single word:** with DEBOUNCE_CYC = 4, enter 8'h81 and then 8'h05 → one `prog_we` pulse with `prog_addr` = 0 and `prog_data` = 16'h8105. Then `word_count` = 1, `state_led` = 001 and `cpu_rst` = 1.
- **Three words then done:** enter 16'h8105, 16'h1100 and 16'hD000, then press done → writes to addresses 0, 1 and 2. After done, `cpu_rst` = 0 and `state_led` = 100. Later byte presses produce no `prog_we`.
- **Bounce and hold:** a key toggling 3 times in under 4 cycles, then held low for 100 cycles → exactly one byte accepted.
- **Partial word and simultaneous press:** high byte 8'hAA entered, then done pressed → no write and `word_count` = 0. Separately, byte and done asserted in the same cycle → DONE with no byte latched.
- **Full memory:** with ADDR_W = 2, enter 4 words → the fourth write goes to address 3, followed by automatic DONE with `word_count` = 4 and `prog_addr` = 0.
- **Reset and checksum:** reset asserted during LOAD_LO → all outputs return to their reset values. With the macro defined, words 16'hFFFF and 16'h0002 give `checksum` = 16'h0001.
